regfile_dump_reader: RTL and testbench

- Read-side initiator for the 32x64 register file. It is the reader counterpart to the write traffic that fills the file.
- On a start pulse it walks an address range (first..last, wrapping past 31 to 0) through one regfile read port.
- It streams each register out as an {address, data} beat on a valid/ready interface, for debug dump, context save and scan-out.
- It sits beside the regfile and connects to rdAddrA/rdDataA (or B) when the datapath is idle.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile32x64.sv | 24 ++
 rtl/regfile_dump_reader.sv | 93 +++++++++
 tb/tb_regfile_dump_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and dump FSM state type for the 32x64 register file slice.
package regfile_pkg;
    localparam int RF_DATA_WIDTH = 64;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;
endpackage

// File: rtl/regfile32x64.sv
// rtl/regfile32x64.sv - 32x64 register file, one synchronous write port, two combinational read ports.
module regfile32x64
    import regfile_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [RF_ADDR_WIDTH-1:0] wrAddr,
    input  logic [RF_DATA_WIDTH-1:0] wrData,
    input  logic [RF_ADDR_WIDTH-1:0] rdAddrA,
    output logic [RF_DATA_WIDTH-1:0] rdDataA,
    input  logic [RF_ADDR_WIDTH-1:0] rdAddrB,
    output logic [RF_DATA_WIDTH-1:0] rdDataB
);
    logic [RF_DATA_WIDTH-1:0] regs [RF_NUM_REGS];

    always_ff @(posedge clk) begin
        if (we) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];
endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a wrapping register range through one regfile read port
// and streams {address, data} beats on a valid/ready interface.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    input  logic [DATA_WIDTH-1:0] rdData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    dump_state_t           state_q;
    dump_state_t           state_d;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (out_ready && out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The read port is addressed by ptr, so every capture samples the register ptr names.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            last_q    <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr    <= first_addr;
                        last_q <= last_addr;
                    end
                end
                LOAD: begin
                    out_data  <= rdData;
                    out_addr  <= ptr;
                    out_last  <= (ptr == last_q);
                    out_valid <= 1'b1;
                    ptr       <= ptr + 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        if (!out_last) begin
                            out_data <= rdData;
                            out_addr <= ptr;
                            out_last <= (ptr == last_q);
                            ptr      <= ptr + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdAddr = ptr;
    assign busy   = (state_q == LOAD) || (state_q == SEND);
    assign done   = (state_q == DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - bench for regfile_dump_reader driving the real regfile32x64.
module tb_regfile_dump_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        we;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;

    int checks = 0;
    int errors = 0;
    logic [63:0] mem [32];

    always #5 clk = ~clk;

    regfile32x64 u_rf (
        .clk     (clk),
        .we      (we),
        .wrAddr  (wr_addr),
        .wrData  (wr_data),
        .rdAddrA (rd_addr),
        .rdDataA (rd_data),
        .rdAddrB (rd_addr_b),
        .rdDataB (rd_data_b)
    );

    regfile_dump_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rdAddr     (rd_addr),
        .rdData     (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        we      = 1'b0;
        mem[a]  = d;
    endtask

    // Expected stream comes from the range rule: ((last-first) mod 32)+1 beats from the model array.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input bit inject, output int nbeats);
        logic [4:0]  ea [$];
        logic [63:0] ed [$];
        logic [4:0]  s_addr;
        logic [63:0] s_data;
        logic        s_last;
        bit          stalled;
        bit          got_last;
        bit          injected;
        bit          rdy;
        int          n;
        int          cyc;
        int          k;
        int          first_valid;
        bit          pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int i = 0; i < n; i++) begin
            ea.push_back(5'((int'(f) + i) % 32));
            ed.push_back(mem[(int'(f) + i) % 32]);
        end
        start = 1'b1; first_addr = f; last_addr = l;
        @(negedge clk);
        start = 1'b0;
        first_addr = 5'($urandom_range(0, 31));
        last_addr  = 5'($urandom_range(0, 31));
        cyc = 1; k = 0; nbeats = 0; first_valid = -1;
        stalled = 0; got_last = 0; injected = 0;
        check("busy_in_load", {63'd0, busy}, 64'd1);
        while (cyc < 300 && !got_last) begin
            start = 1'b0;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stalled && out_valid) begin
                check("stall_addr", {59'd0, out_addr}, {59'd0, s_addr});
                check("stall_data", out_data, s_data);
                check("stall_last", {63'd0, out_last}, {63'd0, s_last});
            end
            stalled = 0;
            if (out_valid) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = pat[k % 6];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                k++;
                out_ready = rdy;
                if (rdy) begin
                    if (nbeats < n) begin
                        check("beat_addr", {59'd0, out_addr}, {59'd0, ea[nbeats]});
                        check("beat_data", out_data, ed[nbeats]);
                        check("beat_last", {63'd0, out_last}, {63'd0, (nbeats == n - 1)});
                    end
                    nbeats++;
                    if (out_last) got_last = 1;
                end else begin
                    stalled = 1;
                    s_addr = out_addr; s_data = out_data; s_last = out_last;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (inject && nbeats == 1 && !injected) begin
                start = 1'b1; first_addr = 5'd10; last_addr = 5'd12;
                injected = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!got_last) begin
            checks++; errors++;
            $display("FAIL dump_timeout: got %0d beats expected %0d", nbeats, n);
        end
        check("beat_count", 64'(nbeats), 64'(n));
        check("first_valid_latency", 64'(first_valid), 64'd2);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("valid_after_last", {63'd0, out_valid}, 64'd0);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         mode;
        bit         inject;
        int         preload;
        int         exp_beats;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   nb;
        int   w;
        logic [4:0] rf;
        logic [4:0] rl;

        vecs[0] = '{5'd0,  5'd3, 0, 1'b0, 1, 4};
        vecs[1] = '{5'd0,  5'd3, 1, 1'b0, 1, 4};
        vecs[2] = '{5'd30, 5'd1, 0, 1'b0, 2, 4};
        vecs[3] = '{5'd7,  5'd7, 0, 1'b0, 3, 1};
        vecs[4] = '{5'd0,  5'd3, 1, 1'b1, 1, 4};
        vecs[5] = '{5'd31, 5'd0, 2, 1'b0, 0, 2};
        vecs[6] = '{5'd5,  5'd4, 2, 1'b0, 0, 32};
        vecs[7] = '{5'd16, 5'd20, 2, 1'b0, 0, 5};

        reset = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0;
        out_ready = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_b = '0;
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_last",  {63'd0, out_last}, 64'd0);
        check("rst_rdaddr", {59'd0, rd_addr}, 64'd0);
        check("rst_out_addr", {59'd0, out_addr}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 32; i++) write_reg(5'(i), {$urandom, $urandom});

        for (int v = 0; v < 8; v++) begin
            case (vecs[v].preload)
                1: begin
                    write_reg(5'd0, 64'hFFFF); write_reg(5'd1, 64'hAAAA);
                    write_reg(5'd2, 64'hCCCC); write_reg(5'd3, 64'hF0F0);
                end
                2: begin
                    write_reg(5'd30, 64'h1E); write_reg(5'd31, 64'h1F);
                    write_reg(5'd0, 64'h00);  write_reg(5'd1, 64'h01);
                end
                3: write_reg(5'd7, 64'h0123456789ABCDEF);
                default: begin
                end
            endcase
            run_dump(vecs[v].f, vecs[v].l, vecs[v].mode, vecs[v].inject, nb);
            check("table_beats", 64'(nb), 64'(vecs[v].exp_beats));
        end

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 3; j++) write_reg(5'($urandom_range(0, 31)), {$urandom, $urandom});
            rf = 5'($urandom_range(0, 31));
            rl = 5'($urandom_range(0, 31));
            run_dump(rf, rl, 2, 1'b0, nb);
        end

        // Reset in the middle of a full-range dump: stream abandoned, no done pulse.
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (w < 20 && !(out_valid && out_addr == 5'd1)) begin
            @(negedge clk);
            w++;
        end
        check("reach_second_beat", {59'd0, out_addr}, 64'd1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_busy",  {63'd0, busy}, 64'd0);
        check("async_rst_done",  {63'd0, done}, 64'd0);
        check("async_rst_rdaddr", {59'd0, rd_addr}, 64'd0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("no_done_in_reset", {63'd0, done}, 64'd0);
        end
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("no_done_after_reset", {63'd0, done}, 64'd0);
        write_reg(5'd5, {$urandom, $urandom});
        run_dump(5'd5, 5'd5, 0, 1'b0, nb);
        check("post_reset_single", 64'(nb), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
